// File: rtl/uio_arb_pkg.sv
// Shared encodings and defaults for uio pad-sharing arbiters.
package uio_arb_pkg;
  localparam int         NUM_REQ         = 2;
  localparam int         TURN_CYCLES_DEF = 1;
  localparam int         MAX_BURST_DEF   = 4;
  localparam logic [7:0] OE_MASK_DEF     = 8'hFF;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    TURN_ON  = 2'd1,
    GRANT    = 2'd2,
    TURN_OFF = 2'd3
  } arb_state_e;

  typedef struct packed {
    logic       valid;
    logic       last;
    logic [7:0] data;
  } req_t;
endpackage

// File: rtl/uio_bus_arbiter_if.sv
// Requester handshakes plus uio pad bus and receive path of the arbiter.
interface uio_bus_arbiter_if;
  logic       r0_valid, r0_last, r0_ready;
  logic [7:0] r0_data;
  logic       r1_valid, r1_last, r1_ready;
  logic [7:0] r1_data;
  logic [7:0] uio_in, uio_out, uio_oe;
  logic [7:0] rx_data;
  logic       rx_valid;

  modport slave (
    input  r0_valid, r0_data, r0_last, r1_valid, r1_data, r1_last, uio_in,
    output r0_ready, r1_ready, uio_out, uio_oe, rx_data, rx_valid
  );
  modport master (
    output r0_valid, r0_data, r0_last, r1_valid, r1_data, r1_last, uio_in,
    input  r0_ready, r1_ready, uio_out, uio_oe, rx_data, rx_valid
  );
endinterface

// File: rtl/uio_bus_arbiter_rr_arb2.sv
// Two-way round-robin pick: on contention the requester that did not own last wins.
module rr_arb2 (
  input  logic [1:0] valid,
  input  logic       last_owner,
  output logic       winner
);
  assign winner = (&valid) ? ~last_owner : valid[1];
endmodule

// File: rtl/uio_bus_arbiter.sv
// Shares the uio pads between two transmit requesters with turnaround gaps
// around every ownership; samples uio_in while nobody drives.
module uio_bus_arbiter
  import uio_arb_pkg::*;
#(
  parameter int         TURN_CYCLES = TURN_CYCLES_DEF,
  parameter int         MAX_BURST   = MAX_BURST_DEF,
  parameter logic [7:0] OE_MASK     = OE_MASK_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  uio_bus_arbiter_if.slave  bus,
  output logic              owner,
  output logic              busy
);
  localparam logic [1:0] TC = 2'(TURN_CYCLES);
  localparam logic [3:0] MB = 4'(MAX_BURST);

  arb_state_e               state, state_nxt;
  logic [1:0]               turn_cnt, turn_nxt;
  logic [3:0]               beat_cnt, beat_nxt;
  logic                     owner_nxt;
  logic [7:0]               out_q, out_nxt, oe_q, oe_nxt;
  req_t [NUM_REQ-1:0]       req;
  logic [NUM_REQ-1:0]       req_vld, ready;
  req_t                     cur;
  logic                     winner, start, beat;

  assign req[0]  = {bus.r0_valid, bus.r0_last, bus.r0_data};
  assign req[1]  = {bus.r1_valid, bus.r1_last, bus.r1_data};
  assign req_vld = {req[1].valid, req[0].valid};
  assign cur     = req[owner];

  assign ready[0] = (state == GRANT) && ena && !owner;
  assign ready[1] = (state == GRANT) && ena &&  owner;
  assign beat     = |(ready & req_vld);
  assign start    = (state == IDLE) && ena && (|req_vld);
  assign busy     = (state != IDLE);

  assign bus.r0_ready = ready[0];
  assign bus.r1_ready = ready[1];
  assign bus.uio_out  = out_q;
  assign bus.uio_oe   = oe_q;

  rr_arb2 u_rr (.valid(req_vld), .last_owner(owner), .winner(winner));

  always_comb begin
    state_nxt = state;
    turn_nxt  = turn_cnt;
    beat_nxt  = beat_cnt;
    owner_nxt = owner;
    out_nxt   = out_q;
    oe_nxt    = oe_q;
    case (state)
      IDLE: if (start) begin
        owner_nxt = winner;
        beat_nxt  = '0;
        if (TC == 2'd0) begin
          state_nxt = GRANT;
          oe_nxt    = OE_MASK;
        end else begin
          state_nxt = TURN_ON;
          turn_nxt  = TC;
        end
      end
      TURN_ON: if (turn_cnt <= 2'd1) begin
        state_nxt = GRANT;
        turn_nxt  = '0;
        oe_nxt    = OE_MASK;
      end else begin
        turn_nxt  = turn_cnt - 2'd1;
      end
      GRANT: begin
        if (beat) begin
          out_nxt = cur.data;
          if (beat_cnt != 4'hF) beat_nxt = beat_cnt + 4'd1;
        end
        if (!ena || !cur.valid || (beat && (cur.last || (beat_cnt + 4'd1 == MB)))) begin
          state_nxt = TURN_OFF;
          turn_nxt  = TC;
        end
      end
      TURN_OFF: begin
        // oe stays up for this first cycle so the final beat gets a full cycle on the pads
        oe_nxt = '0;
        if (turn_cnt == 2'd0) state_nxt = IDLE;
        else                  turn_nxt  = turn_cnt - 2'd1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      turn_cnt     <= '0;
      beat_cnt     <= '0;
      owner        <= 1'b1;
      out_q        <= '0;
      oe_q         <= '0;
      bus.rx_data  <= '0;
      bus.rx_valid <= 1'b0;
    end else begin
      state    <= state_nxt;
      turn_cnt <= turn_nxt;
      beat_cnt <= beat_nxt;
      owner    <= owner_nxt;
      out_q    <= out_nxt;
      oe_q     <= oe_nxt;
      // skip the sample on the grant cycle so rx_valid never shows during turnaround
      if (state == IDLE && oe_q == 8'h00 && !start) begin
        bus.rx_data  <= bus.uio_in;
        bus.rx_valid <= 1'b1;
      end else begin
        bus.rx_valid <= 1'b0;
      end
    end
  end
endmodule
